// File: rtl/core_pkg.sv
// Shared definitions for the pipeline hazard logic: forward-select encodings,
// the per-stage register record, and the "record writes register r" test.
package core_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_BANK = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              reg_write;
        logic              is_load;
    } stage_rec_t;

    // x0 is hardwired zero, so a write to it never produces a usable result.
    function automatic logic rec_writes(input stage_rec_t rec, input logic [REG_AW-1:0] r);
        return rec.valid & rec.reg_write & (rec.rd == r) & (rec.rd != ZERO_REG);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: shadows the E/M/W register records and derives
// stall, flush and operand-forward controls plus stall/flush event counters.
module hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int CNT_W     = 16,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              reg_write_d,
    input  logic              is_load_d,
    input  logic              pc_src_e,
    input  logic              mem_stall,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              forward_a_d,
    output logic              forward_b_d,
    output logic [CNT_W-1:0]  lw_stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    import core_pkg::*;

    stage_rec_t e_rec, m_rec, w_rec;
    stage_rec_t d_rec;
    logic       lw_hz;
    logic       lw_inc;
    logic       flush_inc;

    assign d_rec = '{valid:     valid_d,
                     rd:        rd_d,
                     rs1:       rs1_d,
                     rs2:       rs2_d,
                     reg_write: reg_write_d,
                     is_load:   is_load_d};

    assign lw_hz = valid_d & e_rec.valid & e_rec.is_load & (e_rec.rd != ZERO_REG) &
                   ((e_rec.rd == rs1_d) | (e_rec.rd == rs2_d));

    // A frozen pipeline must not flush: pc_src_e is held until release.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
        end else begin
            stall_f = lw_hz & ~pc_src_e;
            stall_d = lw_hz & ~pc_src_e;
            flush_d = pc_src_e;
            flush_e = lw_hz | pc_src_e;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_rec <= '0;
            m_rec <= '0;
            w_rec <= '0;
        end else if (!mem_stall) begin
            w_rec <= m_rec;
            m_rec <= e_rec;
            e_rec <= flush_e ? stage_rec_t'('0) : d_rec;
        end
    end

    // The newer result in M wins over the older one in W.
    always_comb begin
        forward_a_e = FWD_BANK;
        forward_b_e = FWD_BANK;
        if (rec_writes(m_rec, e_rec.rs1)) begin
            forward_a_e = FWD_MEM;
        end else if (rec_writes(w_rec, e_rec.rs1)) begin
            forward_a_e = FWD_WB;
        end
        if (rec_writes(m_rec, e_rec.rs2)) begin
            forward_b_e = FWD_MEM;
        end else if (rec_writes(w_rec, e_rec.rs2)) begin
            forward_b_e = FWD_WB;
        end
    end

    // The bank commits the W write one edge after D reads it asynchronously.
    generate
        if (WB_BYPASS) begin : gen_wb_bypass
            assign forward_a_d = rec_writes(w_rec, rs1_d);
            assign forward_b_d = rec_writes(w_rec, rs2_d);
        end else begin : gen_no_bypass
            assign forward_a_d = 1'b0;
            assign forward_b_d = 1'b0;
        end
    endgenerate

    assign lw_inc    = ~mem_stall & lw_hz & ~pc_src_e;
    assign flush_inc = ~mem_stall & pc_src_e;

    sat_counter #(.CNT_W(CNT_W)) u_lw_cnt (
        .clk (clk),
        .rst (rst),
        .inc (lw_inc),
        .q   (lw_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .q   (flush_cnt)
    );

endmodule
